// File: rtl/riscv_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : riscv_defs                                                   |
// | Description : RV32 instruction match/mask constants, NOP encoding and the  |
// |               class-flag bundle shared by the fetch->decode buffer.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riscv_defs;

    // An instruction matches INST_x when (instr & INST_x_MASK) == INST_x.
    // ALU register/immediate forms
    localparam logic [31:0] INST_ADDI   = 32'h0000_0013, INST_ADDI_MASK   = 32'h0000_707f;
    localparam logic [31:0] INST_SLTI   = 32'h0000_2013, INST_SLTI_MASK   = 32'h0000_707f;
    localparam logic [31:0] INST_SLTIU  = 32'h0000_3013, INST_SLTIU_MASK  = 32'h0000_707f;
    localparam logic [31:0] INST_XORI   = 32'h0000_4013, INST_XORI_MASK   = 32'h0000_707f;
    localparam logic [31:0] INST_ORI    = 32'h0000_6013, INST_ORI_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_ANDI   = 32'h0000_7013, INST_ANDI_MASK   = 32'h0000_707f;
    localparam logic [31:0] INST_SLLI   = 32'h0000_1013, INST_SLLI_MASK   = 32'hfc00_707f;
    localparam logic [31:0] INST_SRLI   = 32'h0000_5013, INST_SRLI_MASK   = 32'hfc00_707f;
    localparam logic [31:0] INST_SRAI   = 32'h4000_5013, INST_SRAI_MASK   = 32'hfc00_707f;
    localparam logic [31:0] INST_ADD    = 32'h0000_0033, INST_ADD_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_SUB    = 32'h4000_0033, INST_SUB_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_SLL    = 32'h0000_1033, INST_SLL_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_SLT    = 32'h0000_2033, INST_SLT_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_SLTU   = 32'h0000_3033, INST_SLTU_MASK   = 32'hfe00_707f;
    localparam logic [31:0] INST_XOR    = 32'h0000_4033, INST_XOR_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_SRL    = 32'h0000_5033, INST_SRL_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_SRA    = 32'h4000_5033, INST_SRA_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_OR     = 32'h0000_6033, INST_OR_MASK     = 32'hfe00_707f;
    localparam logic [31:0] INST_AND    = 32'h0000_7033, INST_AND_MASK    = 32'hfe00_707f;
    // Upper immediates and control transfer
    localparam logic [31:0] INST_LUI    = 32'h0000_0037, INST_LUI_MASK    = 32'h0000_007f;
    localparam logic [31:0] INST_AUIPC  = 32'h0000_0017, INST_AUIPC_MASK  = 32'h0000_007f;
    localparam logic [31:0] INST_JAL    = 32'h0000_006f, INST_JAL_MASK    = 32'h0000_007f;
    localparam logic [31:0] INST_JALR   = 32'h0000_0067, INST_JALR_MASK   = 32'h0000_707f;
    localparam logic [31:0] INST_BEQ    = 32'h0000_0063, INST_BEQ_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_BNE    = 32'h0000_1063, INST_BNE_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_BLT    = 32'h0000_4063, INST_BLT_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_BGE    = 32'h0000_5063, INST_BGE_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_BLTU   = 32'h0000_6063, INST_BLTU_MASK   = 32'h0000_707f;
    localparam logic [31:0] INST_BGEU   = 32'h0000_7063, INST_BGEU_MASK   = 32'h0000_707f;
    // Loads and stores
    localparam logic [31:0] INST_LB     = 32'h0000_0003, INST_LB_MASK     = 32'h0000_707f;
    localparam logic [31:0] INST_LH     = 32'h0000_1003, INST_LH_MASK     = 32'h0000_707f;
    localparam logic [31:0] INST_LW     = 32'h0000_2003, INST_LW_MASK     = 32'h0000_707f;
    localparam logic [31:0] INST_LBU    = 32'h0000_4003, INST_LBU_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_LHU    = 32'h0000_5003, INST_LHU_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_LWU    = 32'h0000_6003, INST_LWU_MASK    = 32'h0000_707f;
    localparam logic [31:0] INST_SB     = 32'h0000_0023, INST_SB_MASK     = 32'h0000_707f;
    localparam logic [31:0] INST_SH     = 32'h0000_1023, INST_SH_MASK     = 32'h0000_707f;
    localparam logic [31:0] INST_SW     = 32'h0000_2023, INST_SW_MASK     = 32'h0000_707f;
    // M extension
    localparam logic [31:0] INST_MUL    = 32'h0200_0033, INST_MUL_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_MULH   = 32'h0200_1033, INST_MULH_MASK   = 32'hfe00_707f;
    localparam logic [31:0] INST_MULHSU = 32'h0200_2033, INST_MULHSU_MASK = 32'hfe00_707f;
    localparam logic [31:0] INST_MULHU  = 32'h0200_3033, INST_MULHU_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_DIV    = 32'h0200_4033, INST_DIV_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_DIVU   = 32'h0200_5033, INST_DIVU_MASK   = 32'hfe00_707f;
    localparam logic [31:0] INST_REM    = 32'h0200_6033, INST_REM_MASK    = 32'hfe00_707f;
    localparam logic [31:0] INST_REMU   = 32'h0200_7033, INST_REMU_MASK   = 32'hfe00_707f;
    // System / CSR / fence
    localparam logic [31:0] INST_CSRRW  = 32'h0000_1073, INST_CSRRW_MASK  = 32'h0000_707f;
    localparam logic [31:0] INST_CSRRS  = 32'h0000_2073, INST_CSRRS_MASK  = 32'h0000_707f;
    localparam logic [31:0] INST_CSRRC  = 32'h0000_3073, INST_CSRRC_MASK  = 32'h0000_707f;
    localparam logic [31:0] INST_CSRRWI = 32'h0000_5073, INST_CSRRWI_MASK = 32'h0000_707f;
    localparam logic [31:0] INST_CSRRSI = 32'h0000_6073, INST_CSRRSI_MASK = 32'h0000_707f;
    localparam logic [31:0] INST_CSRRCI = 32'h0000_7073, INST_CSRRCI_MASK = 32'h0000_707f;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073, INST_ECALL_MASK  = 32'hffff_ffff;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073, INST_EBREAK_MASK = 32'hffff_ffff;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073, INST_MRET_MASK   = 32'hffff_ffff;
    localparam logic [31:0] INST_FENCE  = 32'h0000_000f, INST_FENCE_MASK  = 32'h0000_707f;

    // addi x0, x0, 0 - substituted for the word of a faulted fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Class-flag bundle; field order is exec (MSB) down to invalid (LSB)
    typedef struct packed {
        logic exec;
        logic lsu;
        logic branch;
        logic mul;
        logic div;
        logic csr;
        logic rd_valid;
        logic invalid;
    } class_flags_t;

    function automatic logic inst_match(input logic [31:0] instr,
                                        input logic [31:0] mask,
                                        input logic [31:0] pattern);
        return (instr & mask) == pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_class_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_class_decode                                           |
// | Description : Combinational pre-classifier: 32-bit instruction word in,    |
// |               eight class flags out.                                       |
// |   i_instr  in  32  instruction word                                        |
// |   o_flags  out  8  class flags (exec/lsu/branch/mul/div/csr/rd_valid/inv)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_class_decode
    import riscv_defs::*;
(
    input  logic [31:0]  i_instr,
    output class_flags_t o_flags
);

    logic w_alu_imm, w_alu_reg, w_lui, w_auipc, w_jal, w_jalr, w_cond_br;
    logic w_load, w_store, w_mul, w_div, w_csr_rw, w_sys;

    assign w_alu_imm = inst_match(i_instr, INST_ADDI_MASK,  INST_ADDI)  | inst_match(i_instr, INST_SLTI_MASK,  INST_SLTI)
                     | inst_match(i_instr, INST_SLTIU_MASK, INST_SLTIU) | inst_match(i_instr, INST_XORI_MASK,  INST_XORI)
                     | inst_match(i_instr, INST_ORI_MASK,   INST_ORI)   | inst_match(i_instr, INST_ANDI_MASK,  INST_ANDI)
                     | inst_match(i_instr, INST_SLLI_MASK,  INST_SLLI)  | inst_match(i_instr, INST_SRLI_MASK,  INST_SRLI)
                     | inst_match(i_instr, INST_SRAI_MASK,  INST_SRAI);
    assign w_alu_reg = inst_match(i_instr, INST_ADD_MASK,  INST_ADD)  | inst_match(i_instr, INST_SUB_MASK,  INST_SUB)
                     | inst_match(i_instr, INST_SLL_MASK,  INST_SLL)  | inst_match(i_instr, INST_SLT_MASK,  INST_SLT)
                     | inst_match(i_instr, INST_SLTU_MASK, INST_SLTU) | inst_match(i_instr, INST_XOR_MASK,  INST_XOR)
                     | inst_match(i_instr, INST_SRL_MASK,  INST_SRL)  | inst_match(i_instr, INST_SRA_MASK,  INST_SRA)
                     | inst_match(i_instr, INST_OR_MASK,   INST_OR)   | inst_match(i_instr, INST_AND_MASK,  INST_AND);
    assign w_lui     = inst_match(i_instr, INST_LUI_MASK,   INST_LUI);
    assign w_auipc   = inst_match(i_instr, INST_AUIPC_MASK, INST_AUIPC);
    assign w_jal     = inst_match(i_instr, INST_JAL_MASK,   INST_JAL);
    assign w_jalr    = inst_match(i_instr, INST_JALR_MASK,  INST_JALR);
    assign w_cond_br = inst_match(i_instr, INST_BEQ_MASK,  INST_BEQ)  | inst_match(i_instr, INST_BNE_MASK,  INST_BNE)
                     | inst_match(i_instr, INST_BLT_MASK,  INST_BLT)  | inst_match(i_instr, INST_BGE_MASK,  INST_BGE)
                     | inst_match(i_instr, INST_BLTU_MASK, INST_BLTU) | inst_match(i_instr, INST_BGEU_MASK, INST_BGEU);
    assign w_load    = inst_match(i_instr, INST_LB_MASK,  INST_LB)  | inst_match(i_instr, INST_LH_MASK,  INST_LH)
                     | inst_match(i_instr, INST_LW_MASK,  INST_LW)  | inst_match(i_instr, INST_LBU_MASK, INST_LBU)
                     | inst_match(i_instr, INST_LHU_MASK, INST_LHU) | inst_match(i_instr, INST_LWU_MASK, INST_LWU);
    assign w_store   = inst_match(i_instr, INST_SB_MASK, INST_SB) | inst_match(i_instr, INST_SH_MASK, INST_SH)
                     | inst_match(i_instr, INST_SW_MASK, INST_SW);
    assign w_mul     = inst_match(i_instr, INST_MUL_MASK,    INST_MUL)    | inst_match(i_instr, INST_MULH_MASK,  INST_MULH)
                     | inst_match(i_instr, INST_MULHSU_MASK, INST_MULHSU) | inst_match(i_instr, INST_MULHU_MASK, INST_MULHU);
    assign w_div     = inst_match(i_instr, INST_DIV_MASK, INST_DIV) | inst_match(i_instr, INST_DIVU_MASK, INST_DIVU)
                     | inst_match(i_instr, INST_REM_MASK, INST_REM) | inst_match(i_instr, INST_REMU_MASK, INST_REMU);
    assign w_csr_rw  = inst_match(i_instr, INST_CSRRW_MASK,  INST_CSRRW)  | inst_match(i_instr, INST_CSRRS_MASK,  INST_CSRRS)
                     | inst_match(i_instr, INST_CSRRC_MASK,  INST_CSRRC)  | inst_match(i_instr, INST_CSRRWI_MASK, INST_CSRRWI)
                     | inst_match(i_instr, INST_CSRRSI_MASK, INST_CSRRSI) | inst_match(i_instr, INST_CSRRCI_MASK, INST_CSRRCI);
    // System instructions that go down the CSR pipe but never write rd
    assign w_sys     = inst_match(i_instr, INST_ECALL_MASK, INST_ECALL) | inst_match(i_instr, INST_EBREAK_MASK, INST_EBREAK)
                     | inst_match(i_instr, INST_MRET_MASK,  INST_MRET)  | inst_match(i_instr, INST_FENCE_MASK,  INST_FENCE);

    always_comb begin
        o_flags          = '0;
        o_flags.exec     = w_alu_imm | w_alu_reg | w_lui | w_auipc | w_jal | w_jalr | w_cond_br;
        o_flags.branch   = w_jal | w_jalr | w_cond_br;
        o_flags.lsu      = w_load | w_store;
        o_flags.mul      = w_mul;
        o_flags.div      = w_div;
        o_flags.csr      = w_csr_rw | w_sys;
        // A write to x0 is discarded, so it does not count as producing rd
        o_flags.rd_valid = (|i_instr[11:7]) & (w_alu_imm | w_alu_reg | w_lui | w_auipc | w_jal | w_jalr
                                               | w_load | w_mul | w_div | w_csr_rw);
        o_flags.invalid  = ~(o_flags.exec | o_flags.lsu | o_flags.mul | o_flags.div | o_flags.csr);
    end

endmodule
`default_nettype wire

// File: rtl/decode_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_fetch_buffer                                          |
// | Description : Fetch->decode skid FIFO. Classifies each instruction as it   |
// |               is written and presents the head entry plus its registered  |
// |               class flags to decode; flushes on squash.                    |
// |   clk_i / rst_i             clock, synchronous active-high reset           |
// |   fetch_in_*                fetch-side valid/instr/pc/fault in, accept out |
// |   squash_decode_i           discard held and incoming entries              |
// |   fetch_out_*               head valid/instr/pc/faults/class flags out,    |
// |                             accept in                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_fetch_buffer
    import riscv_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_in_valid_i,
    input  logic [31:0] fetch_in_instr_i,
    input  logic [31:0] fetch_in_pc_i,
    input  logic        fetch_in_fault_fetch_i,
    input  logic        fetch_in_fault_page_i,
    output logic        fetch_in_accept_o,
    input  logic        squash_decode_i,
    output logic        fetch_out_valid_o,
    output logic [31:0] fetch_out_instr_o,
    output logic [31:0] fetch_out_pc_o,
    output logic        fetch_out_fault_fetch_o,
    output logic        fetch_out_fault_page_o,
    output logic        fetch_out_instr_exec_o,
    output logic        fetch_out_instr_lsu_o,
    output logic        fetch_out_instr_branch_o,
    output logic        fetch_out_instr_mul_o,
    output logic        fetch_out_instr_div_o,
    output logic        fetch_out_instr_csr_o,
    output logic        fetch_out_instr_rd_valid_o,
    output logic        fetch_out_instr_invalid_o,
    input  logic        fetch_out_accept_i
);

    localparam logic [PTR_W:0] c_count_full = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_instr_q [DEPTH];
    logic [31:0]      r_pc_q    [DEPTH];
    logic             r_ffetch_q[DEPTH];
    logic             r_fpage_q [DEPTH];
    class_flags_t     r_flags_q [DEPTH];

    logic             w_push, w_pop;
    class_flags_t     w_dec_flags, w_wr_flags, w_head_flags;
    logic [31:0]      w_wr_instr;

    // Accept is a function of occupancy only, so a full buffer stays closed
    // even when decode drains it in the same cycle.
    assign fetch_in_accept_o = (r_count != c_count_full);
    assign fetch_out_valid_o = (r_count != '0);
    assign w_push = fetch_in_valid_i & fetch_in_accept_o & ~squash_decode_i;
    assign w_pop  = fetch_out_valid_o & fetch_out_accept_i;

    instr_class_decode u_class (
        .i_instr (fetch_in_instr_i),
        .o_flags (w_dec_flags)
    );

    // A faulted fetch carries no usable word: store a NOP with no class.
    always_comb begin
        w_wr_instr = fetch_in_instr_i;
        w_wr_flags = w_dec_flags;
        if (fetch_in_fault_fetch_i | fetch_in_fault_page_i) begin
            w_wr_instr = NOP_INSTR;
            w_wr_flags = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_q[i]  <= '0;
                r_pc_q[i]     <= '0;
                r_ffetch_q[i] <= 1'b0;
                r_fpage_q[i]  <= 1'b0;
                r_flags_q[i]  <= '0;
            end
        end else if (squash_decode_i) begin
            // Storage is left as-is; with count at zero it is never exposed as valid.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr_q[r_wr_ptr]  <= w_wr_instr;
                r_pc_q[r_wr_ptr]     <= fetch_in_pc_i;
                r_ffetch_q[r_wr_ptr] <= fetch_in_fault_fetch_i;
                r_fpage_q[r_wr_ptr]  <= fetch_in_fault_page_i;
                r_flags_q[r_wr_ptr]  <= w_wr_flags;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_flags               = r_flags_q[r_rd_ptr];
    assign fetch_out_instr_o          = r_instr_q[r_rd_ptr];
    assign fetch_out_pc_o             = r_pc_q[r_rd_ptr];
    assign fetch_out_fault_fetch_o    = r_ffetch_q[r_rd_ptr];
    assign fetch_out_fault_page_o     = r_fpage_q[r_rd_ptr];
    assign fetch_out_instr_exec_o     = w_head_flags.exec;
    assign fetch_out_instr_lsu_o      = w_head_flags.lsu;
    assign fetch_out_instr_branch_o   = w_head_flags.branch;
    assign fetch_out_instr_mul_o      = w_head_flags.mul;
    assign fetch_out_instr_div_o      = w_head_flags.div;
    assign fetch_out_instr_csr_o      = w_head_flags.csr;
    assign fetch_out_instr_rd_valid_o = w_head_flags.rd_valid;
    assign fetch_out_instr_invalid_o  = w_head_flags.invalid;

endmodule
`default_nettype wire

// File: tb/tb_decode_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decode_fetch_buffer                                       |
// | Description : Self-checking bench for decode_fetch_buffer: directed        |
// |               scenarios plus randomized traffic against a queue model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decode_fetch_buffer;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ff;
        logic        fp;
        logic [7:0]  flags;   // exec,lsu,branch,mul,div,csr,rd_valid,invalid
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ff, in_fp, squash, out_accept;
    logic [31:0] in_instr, in_pc;
    logic        in_accept, out_valid, out_ff, out_fp;
    logic [31:0] out_instr, out_pc;
    logic        f_exec, f_lsu, f_branch, f_mul, f_div, f_csr, f_rd, f_inv;
    logic [7:0]  obs_flags;
    ent_t        obs;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    assign obs_flags = {f_exec, f_lsu, f_branch, f_mul, f_div, f_csr, f_rd, f_inv};
    assign obs       = {out_instr, out_pc, out_ff, out_fp, obs_flags};

    decode_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .fetch_in_valid_i           (in_valid),
        .fetch_in_instr_i           (in_instr),
        .fetch_in_pc_i              (in_pc),
        .fetch_in_fault_fetch_i     (in_ff),
        .fetch_in_fault_page_i      (in_fp),
        .fetch_in_accept_o          (in_accept),
        .squash_decode_i            (squash),
        .fetch_out_valid_o          (out_valid),
        .fetch_out_instr_o          (out_instr),
        .fetch_out_pc_o             (out_pc),
        .fetch_out_fault_fetch_o    (out_ff),
        .fetch_out_fault_page_o     (out_fp),
        .fetch_out_instr_exec_o     (f_exec),
        .fetch_out_instr_lsu_o      (f_lsu),
        .fetch_out_instr_branch_o   (f_branch),
        .fetch_out_instr_mul_o      (f_mul),
        .fetch_out_instr_div_o      (f_div),
        .fetch_out_instr_csr_o      (f_csr),
        .fetch_out_instr_rd_valid_o (f_rd),
        .fetch_out_instr_invalid_o  (f_inv),
        .fetch_out_accept_i         (out_accept)
    );

    // Reference classifier written from the ISA field layout (opcode/funct3/funct7).
    function automatic logic [7:0] classify(input logic [31:0] i);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic exec, lsu, br, mul, dv, csr, wr;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        exec = 0; lsu = 0; br = 0; mul = 0; dv = 0; csr = 0; wr = 0;
        case (op)
            7'h13: begin
                if (f3 == 3'd1)      exec = (f7[6:1] == 6'h00);
                else if (f3 == 3'd5) exec = (f7[6:1] == 6'h00) || (f7[6:1] == 6'h10);
                else                 exec = 1;
                wr = exec;
            end
            7'h33: begin
                if (f7 == 7'h00)      exec = 1;
                else if (f7 == 7'h20) exec = (f3 == 3'd0) || (f3 == 3'd5);
                else if (f7 == 7'h01) begin mul = (f3 < 3'd4); dv = (f3 >= 3'd4); end
                wr = exec | mul | dv;
            end
            7'h37, 7'h17: begin exec = 1; wr = 1; end
            7'h6f:        begin exec = 1; br = 1; wr = 1; end
            7'h67:        if (f3 == 3'd0) begin exec = 1; br = 1; wr = 1; end
            7'h63:        if (f3 != 3'd2 && f3 != 3'd3) begin exec = 1; br = 1; end
            7'h03:        if (f3 != 3'd3 && f3 != 3'd7) begin lsu = 1; wr = 1; end
            7'h23:        lsu = (f3 < 3'd3);
            7'h73: begin
                if (f3 == 3'd0)      csr = (i == 32'h0000_0073) || (i == 32'h0010_0073) || (i == 32'h3020_0073);
                else if (f3 != 3'd4) begin csr = 1; wr = 1; end
            end
            7'h0f:        csr = (f3 == 3'd0);
            default: ;
        endcase
        wr = wr && (i[11:7] != 5'd0);
        return {exec, lsu, br, mul, dv, csr, wr, !(exec | lsu | mul | dv | csr)};
    endfunction

    function automatic ent_t make_entry(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic ff, input logic fp);
        ent_t e;
        e.pc = pc; e.ff = ff; e.fp = fp;
        e.instr = (ff | fp) ? 32'h0000_0013 : instr;
        e.flags = (ff | fp) ? 8'h00 : classify(instr);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 12))
            0:  begin i[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            1:  begin
                    i[6:0] = 7'h33;
                    case ($urandom_range(0, 3))
                        0: i[31:25] = 7'h00;
                        1: i[31:25] = 7'h20;
                        2: i[31:25] = 7'h01;
                        default: ;
                    endcase
                end
            2:  i[6:0] = 7'h37;
            3:  i[6:0] = 7'h17;
            4:  i[6:0] = 7'h6f;
            5:  i[6:0] = 7'h67;
            6:  i[6:0] = 7'h63;
            7:  i[6:0] = 7'h03;
            8:  i[6:0] = 7'h23;
            9:  i[6:0] = 7'h73;
            10: case ($urandom_range(0, 2))
                    0: i = 32'h0000_0073;
                    1: i = 32'h0010_0073;
                    default: i = 32'h3020_0073;
                endcase
            11: i[6:0] = 7'h0f;
            default: ;
        endcase
        return i;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic ff, input logic fp, input logic oacc, input logic sq);
        in_valid = v; in_instr = instr; in_pc = pc; in_ff = ff; in_fp = fp;
        out_accept = oacc; squash = sq;
    endtask

    // Advance one clock and apply the same transfer rules to the model queue.
    task automatic tick();
        logic push, pop;
        push = in_valid && (q.size() != DEPTH) && !squash;
        pop  = (q.size() != 0) && out_accept;
        @(posedge clk);
        if (rst || squash) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(make_entry(in_instr, in_pc, in_ff, in_fp));
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h00A0_0093, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
            checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL reset_accept: got %0b want 1", in_accept); end
            checks++; if (obs !== ent_t'(0)) begin errors++; $display("FAIL reset_payload: got %h want 0", obs); end
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_write: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_single_pass();
        drive(1'b1, 32'h00A0_0093, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL single_pc: got %h want 00000100", out_pc); end
        checks++; if (obs_flags !== 8'b1000_0010) begin errors++; $display("FAIL single_flags: got %b want 10000010", obs_flags); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h13, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_full_accept: got %0b want 0", in_accept); end
        drive(1'b1, 32'h13, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        checks++; if ({out_valid, in_accept, out_pc} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL bp_hold: got v=%0b a=%0b pc=%h want v=1 a=0 pc=00000000", out_valid, in_accept, out_pc); end
        out_accept = 1'b1; tick();
        checks++; if ({out_valid, in_accept, out_pc} !== {1'b1, 1'b1, 32'h4}) begin
            errors++; $display("FAIL bp_release1: got v=%0b a=%0b pc=%h want v=1 a=1 pc=00000004", out_valid, in_accept, out_pc); end
        tick();
        checks++; if ({out_valid, out_pc} !== {1'b1, 32'h8}) begin
            errors++; $display("FAIL bp_release2: got v=%0b pc=%h want v=1 pc=00000008", out_valid, out_pc); end
        in_valid = 1'b0; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        for (int k = 0; k < 10; k++) begin
            pc = 32'h200 + 32'(4 * k);
            drive(1'b1, 32'h0000_0093 | (32'(k) << 20), pc, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            checks++; if ({out_valid, in_accept, out_pc} !== {1'b1, 1'b1, pc}) begin
                errors++; $display("FAIL wrap_beat%0d: got v=%0b a=%0b pc=%h want v=1 a=1 pc=%h", k, out_valid, in_accept, out_pc, pc); end
        end
        in_valid = 1'b0; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_squash();
        drive(1'b1, 32'h13, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h13, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL squash_prefull: accept got %0b want 0", in_accept); end
        drive(1'b1, 32'h13, 32'h308, 1'b0, 1'b0, 1'b1, 1'b1); tick();
        checks++; if ({out_valid, in_accept} !== 2'b01) begin
            errors++; $display("FAIL squash_flush: got v=%0b a=%0b want v=0 a=1", out_valid, in_accept); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL squash_beat_dropped: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_classes();
        logic [31:0] ins [6];
        logic [7:0]  exp [6];
        logic        fp  [6];
        logic        ff  [6];
        ins = '{32'h00C1_2083, 32'h0020_8463, 32'h0220_8033, 32'hFFFF_FFFF, 32'h00C1_2083, 32'h0220_C0B3};
        exp = '{8'b0100_0010, 8'b1010_0000, 8'b0001_0000, 8'b0000_0001, 8'b0000_0000, 8'b0000_1010};
        fp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ff  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, ins[k], 32'h400 + 32'(4 * k), ff[k], fp[k], 1'b1, 1'b0);
            tick();
            checks++; if (obs_flags !== exp[k]) begin
                errors++; $display("FAIL class%0d_flags: got %b want %b", k, obs_flags, exp[k]); end
            checks++; if ({out_instr, out_fp} !== {(fp[k] ? 32'h13 : ins[k]), fp[k]}) begin
                errors++; $display("FAIL class%0d_instr: got %h fp=%0b want %h fp=%0b", k, out_instr, out_fp,
                                   (fp[k] ? 32'h13 : ins[k]), fp[k]); end
        end
        drive(1'b1, 32'h0020_8463, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        checks++; if ({out_instr, out_ff, obs_flags} !== {32'h13, 1'b1, 8'h00}) begin
            errors++; $display("FAIL fault_fetch: got instr=%h ff=%0b flags=%b want 00000013 1 00000000", out_instr, out_ff, obs_flags); end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            tick();
            checks++; if ({out_valid, in_accept} !== {q.size() != 0, q.size() != DEPTH}) begin
                errors++; $display("FAIL rand%0d_state: got v=%0b a=%0b want v=%0b a=%0b", n, out_valid, in_accept,
                                   q.size() != 0, q.size() != DEPTH); end
            if (q.size() != 0) begin
                checks++; if (obs !== q[0]) begin
                    errors++; $display("FAIL rand%0d_head: got %h want %h", n, obs, q[0]); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single_pass();
        test_back_pressure();
        test_wrap();
        test_squash();
        test_classes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
